// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; a clear coinciding with an increment loads 1 so that event is kept.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial bit-pattern detector with a registered one-cycle match pulse.
// Defining SEQ_DET_CNT_EN adds the saturating match counter (match_cnt / cnt_clr).
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011,
    parameter logic             DEF_OVL = OVL_ON,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic             dout,
    output logic             busy_fill
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
`endif
);

    localparam int            FW   = fill_width(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    if (PAT_W < 2) begin : g_bad_pat_w
        $error("seq_det_prog: PAT_W must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_det_prog: CNT_W must be at least 1");
    end

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    // Only the newest PAT_W-1 bits are stored; the full window is formed with din.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;

    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill_n;
    logic             hit;

    always_comb begin
        hist_n = {hist_q, din};
        fill_n = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        hit    = 1'b0;
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        dout_d = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            fill_d = '0;
        end else if (din_valid) begin
            hit    = (fill_n == FULL) && (hist_n == pat_q);
            hist_d = hist_n[PAT_W-2:0];
            dout_d = hit;
            fill_d = (hit && (ovl_q == OVL_OFF)) ? '0 : fill_n;
        end
        busy_d = (fill_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEF_PAT;
            ovl_q  <= DEF_OVL;
            hist_q <= '0;
            fill_q <= '0;
            dout_q <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            dout_q <= dout_d;
            busy_q <= busy_d;
        end
    end

    assign dout      = dout_q;
    assign busy_fill = busy_q;

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (dout_d),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );
`endif

endmodule
